// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch port and a data port.
// One transaction is outstanding at a time; data has priority, with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {OWN_DATA, OWN_FETCH} owner_e;

  state_e        state, state_next;
  owner_e        owner;
  logic          drop;
  logic [CW-1:0] starve_cnt;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          pick_fetch;

  assign pick_fetch = if_req && (!dm_req || starve_cnt == STARVE_LIMIT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    mem_req    = 1'b0;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    case (state)
      IDLE: if (if_req || dm_req) state_next = REQ;
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if_gnt     = (owner == OWN_FETCH);
          dm_gnt     = (owner == OWN_DATA);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          // A flush arriving with the response kills it just like an earlier flush.
          if_rvalid  = (owner == OWN_FETCH) && !drop && !if_flush;
          dm_rvalid  = (owner == OWN_DATA);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_DATA;
      drop       <= 1'b0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && (if_req || dm_req)) begin
        if (pick_fetch) begin
          owner   <= OWN_FETCH;
          we_q    <= 1'b0;
          be_q    <= 4'hF;
          addr_q  <= if_addr;
          wdata_q <= '0;
        end else begin
          owner   <= OWN_DATA;
          we_q    <= dm_we;
          be_q    <= dm_be;
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
        end
      end

      // Counts data grants taken while a fetch was kept waiting.
      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (dm_gnt) begin
        if (!if_req)                         starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + CW'(1);
      end

      if (state == IDLE || (state == WAIT && mem_rvalid)) drop <= 1'b0;
      else if (owner == OWN_FETCH && if_flush)            drop <= 1'b1;
    end
  end

endmodule
